// File: rtl/mod_mult.sv
// rtl/mod_mult.sv - sequential (x*y) mod n, MSB-first shift-add-reduce; optional done port via MODMULT_DONE_EN
module mod_mult #(
    parameter int N  = 8,
    parameter int CC = N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] n,
`ifdef MODMULT_DONE_EN
    output logic         done,
`endif
    output logic [N-1:0] o
);

    localparam int K  = N / CC;
    localparam int CW = $clog2(CC + 1);

    logic [N-1:0]  acc;
    logic [N-1:0]  xs;
    logic [N-1:0]  ys;
    logic [N-1:0]  ns;
    logic [CW-1:0] cnt;
    logic          busy;

    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  xs_nxt;

    // One bit of x: t = 2*acc + b*y, then at most two conditional subtractions of n.
    function automatic logic [N-1:0] step(
        input logic [N-1:0] a,
        input logic         b,
        input logic [N-1:0] yv,
        input logic [N-1:0] nv
    );
        logic [N+1:0] t;
        logic [N+1:0] nn;
        nn = {2'b00, nv};
        t  = {1'b0, a, 1'b0} + (b ? {2'b00, yv} : {(N+2){1'b0}});
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t[N-1:0];
    endfunction

    // A start edge works on the live operands from a zero accumulator.
    always_comb begin
        logic [N-1:0] src;
        logic [N-1:0] yc;
        logic [N-1:0] nc;
        logic [N-1:0] a;
        src = start ? x : xs;
        yc  = start ? y : ys;
        nc  = start ? n : ns;
        a   = start ? '0 : acc;
        for (int i = 0; i < K; i++) begin
            a = step(a, src[N-1-i], yc, nc);
        end
        acc_nxt = a;
        xs_nxt  = src << K;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            xs   <= '0;
            ys   <= '0;
            ns   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
`ifdef MODMULT_DONE_EN
            done <= 1'b0;
`endif
        end else if (start) begin
            acc  <= acc_nxt;
            xs   <= xs_nxt;
            ys   <= y;
            ns   <= n;
            cnt  <= CW'(CC - 1);
            busy <= (CC > 1);
`ifdef MODMULT_DONE_EN
            done <= (CC == 1);
`endif
        end else if (busy) begin
            acc <= acc_nxt;
            xs  <= xs_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
`ifdef MODMULT_DONE_EN
            done <= (cnt == CW'(1));
`endif
        end else begin
`ifdef MODMULT_DONE_EN
            done <= 1'b0;
`endif
        end
    end

    assign o = acc;

endmodule

// File: tb/tb_mod_mult.sv
// tb/tb_mod_mult.sv - directed checks of mod_mult at CC=8, CC=4 and CC=1
module tb_mod_mult;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic [7:0] n = 8'd1;
    logic [7:0] o8;
    logic [7:0] o4;
    logic [7:0] o1;
`ifdef MODMULT_DONE_EN
    logic       done8;
    logic       done4;
    logic       done1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_mult #(.N(8), .CC(8)) u_cc8 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .n(n),
`ifdef MODMULT_DONE_EN
        .done(done8),
`endif
        .o(o8)
    );

    mod_mult #(.N(8), .CC(4)) u_cc4 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .n(n),
`ifdef MODMULT_DONE_EN
        .done(done4),
`endif
        .o(o4)
    );

    mod_mult #(.N(8), .CC(1)) u_cc1 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .n(n),
`ifdef MODMULT_DONE_EN
        .done(done1),
`endif
        .o(o1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns just after the edge that sampled start (edge 1).
    task automatic launch(input logic [7:0] xv, input logic [7:0] yv, input logic [7:0] nv);
        x     = xv;
        y     = yv;
        n     = nv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                       input logic [7:0] nv, input logic [7:0] exp);
        launch(xv, yv, nv);
        check({tag, "_cc1"}, o1, exp);
        repeat (3) @(negedge clk);
        check({tag, "_cc4"}, o4, exp);
        repeat (4) @(negedge clk);
        check({tag, "_cc8"}, o8, exp);
`ifdef MODMULT_DONE_EN
        check({tag, "_done8"}, done8, 1);
        @(negedge clk);
        check({tag, "_done8_off"}, done8, 0);
`endif
    endtask

    initial begin
        @(negedge clk);
        check("reset_o8", o8, 0);
        check("reset_o4", o4, 0);
        check("reset_o1", o1, 0);
`ifdef MODMULT_DONE_EN
        check("reset_done8", done8, 0);
`endif
        rst = 1'b1;
        @(negedge clk);

        run("m45_37", 8'd45, 8'd37, 8'd107, 8'd60);
        repeat (10) @(negedge clk);
        check("hold_o8", o8, 60);
        check("hold_o4", o4, 60);

        run("m255_106", 8'd255, 8'd106, 8'd107, 8'd66);
        run("m254_254", 8'd254, 8'd254, 8'd255, 8'd1);
        run("m0_5", 8'd0, 8'd5, 8'd7, 8'd0);

        // asynchronous reset in the 4th cycle of a run
        launch(8'd45, 8'd37, 8'd107);
        repeat (2) @(negedge clk);
        check("partial_e3", o8, 37);
        #2 rst = 1'b0;
        #1 check("async_rst", o8, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_stays0", o8, 0);

        // restart at edge 3 with 12*100 mod 101
        launch(8'd45, 8'd37, 8'd107);
        @(negedge clk);
        launch(8'd12, 8'd100, 8'd101);
        for (int e = 3; e <= 9; e++) begin
`ifdef MODMULT_DONE_EN
            check($sformatf("restart_nodone_e%0d", e), done8, 0);
`endif
            if (e == 8) check("restart_e8_partial", o8, 98);
            @(negedge clk);
        end
        check("restart_e10", o8, 89);
`ifdef MODMULT_DONE_EN
        check("restart_done_e10", done8, 1);
        @(negedge clk);
        check("restart_done_off", done8, 0);
`endif

        // operands change after the start edge
        launch(8'd45, 8'd37, 8'd107);
        x = 8'd1;
        y = 8'd1;
        n = 8'd2;
        repeat (7) @(negedge clk);
        check("late_operands", o8, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
